// File: rtl/region_color_vote.sv
// Per-frame colour vote: classifies each written pixel into one of six classes, counts per class
// for each cell of a 3x3 grid, and resolves the winning class per cell at end of frame.
module region_color_vote #(
  parameter int unsigned LINE_LENGTH = 480,
  parameter int unsigned LINE_COUNT  = 480,
  parameter int unsigned ADDR_WIDTH  = 18,
  parameter int unsigned CNT_WIDTH   = 15,
  parameter int unsigned SAT_MIN     = 32,
  parameter int unsigned DARK_MAX    = 24,
  parameter int unsigned WHITE_MIN   = 48,
  parameter int unsigned MIN_COUNT   = 256
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_flush,
  input  logic [15:0]           i_data,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_valid,
  output logic [2:0]            o_color0,
  output logic [2:0]            o_color1,
  output logic [2:0]            o_color2,
  output logic [2:0]            o_color3,
  output logic [2:0]            o_color4,
  output logic [2:0]            o_color5,
  output logic [2:0]            o_color6,
  output logic [2:0]            o_color7,
  output logic [2:0]            o_color8,
  output logic                  o_frame_done,
  output logic                  o_sync_err,
  output logic                  o_drop_err
);

  localparam int unsigned XW = (LINE_LENGTH > 2) ? $clog2(LINE_LENGTH) : 1;
  localparam int unsigned YW = (LINE_COUNT > 2) ? $clog2(LINE_COUNT) : 1;
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(LINE_LENGTH * LINE_COUNT - 1);

  typedef enum logic [2:0] {StWaitSof, StAccum, StDrain, StResolve, StCommit} state_e;

  state_e                  state_q, state_d;
  logic [XW-1:0]           x_q, x_d;
  logic [YW-1:0]           y_q, y_d;
  logic [ADDR_WIDTH-1:0]   exp_q, exp_d;
  logic                    drain_q, drain_d;
  logic [3:0]              idx_q, idx_d;
  logic                    take, at_origin, clr_cnt, set_sync, set_drop, commit;

  logic                    s1_valid_q;
  logic [2:0]              s1_class_q;
  logic [3:0]              s1_cell_q;
  logic [CNT_WIDTH-1:0]    cnt_q [9][5];
  logic [2:0]              shadow_q [9];
  logic [2:0]              color_q [9];
  logic                    frame_done_q, sync_err_q, drop_err_q;

  // Classification of the incoming pixel
  logic [5:0] r6, g6, b6;
  logic [2:0] class_in;
  always_comb begin
    r6 = {i_data[15:11], i_data[15]};
    g6 = i_data[10:5];
    b6 = {i_data[4:0], i_data[4]};
    class_in = 3'd0;
    if (r6 >= 6'(WHITE_MIN) && g6 >= 6'(WHITE_MIN) && b6 >= 6'(WHITE_MIN)) begin
      class_in = 3'd1;
    end else if (r6 >= 6'(SAT_MIN) && g6 >= 6'(SAT_MIN) && b6 < 6'(DARK_MAX)) begin
      class_in = 3'd2;
    end else if (r6 >= 6'(SAT_MIN) && g6 < 6'(DARK_MAX) && b6 < 6'(DARK_MAX)) begin
      class_in = 3'd3;
    end else if (g6 >= 6'(SAT_MIN) && r6 < 6'(DARK_MAX) && b6 < 6'(DARK_MAX)) begin
      class_in = 3'd4;
    end else if (b6 >= 6'(SAT_MIN) && r6 < 6'(DARK_MAX) && g6 < 6'(DARK_MAX)) begin
      class_in = 3'd5;
    end
  end

  // Cell of the incoming pixel; a frame-start pixel is always at the origin
  logic [XW-1:0] px_x;
  logic [YW-1:0] px_y;
  logic [1:0]    cx, cy;
  logic [3:0]    cell_in;
  always_comb begin
    px_x = at_origin ? '0 : x_q;
    px_y = at_origin ? '0 : y_q;
    cx = (px_x < XW'(LINE_LENGTH / 3)) ? 2'd0 :
         (px_x < XW'(2 * LINE_LENGTH / 3)) ? 2'd1 : 2'd2;
    cy = (px_y < YW'(LINE_COUNT / 3)) ? 2'd0 :
         (px_y < YW'(2 * LINE_COUNT / 3)) ? 2'd1 : 2'd2;
    cell_in = {2'b00, cy} * 4'd3 + {2'b00, cx};
  end

  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    exp_d     = exp_q;
    drain_d   = drain_q;
    idx_d     = idx_q;
    take      = 1'b0;
    at_origin = 1'b0;
    clr_cnt   = 1'b0;
    set_sync  = 1'b0;
    set_drop  = 1'b0;
    commit    = 1'b0;
    if (i_flush) begin
      state_d = StWaitSof;
      clr_cnt = 1'b1;
      x_d     = '0;
      y_d     = '0;
      exp_d   = '0;
      drain_d = 1'b0;
      idx_d   = '0;
    end else begin
      unique case (state_q)
        StWaitSof: begin
          if (i_valid && i_addr == '0) begin
            take      = 1'b1;
            at_origin = 1'b1;
            x_d       = XW'(1);
            y_d       = '0;
            exp_d     = ADDR_WIDTH'(1);
            state_d   = StAccum;
          end
        end
        StAccum: begin
          if (i_valid) begin
            if (i_addr == exp_q) begin
              take = 1'b1;
              if (i_addr == LastAddr) begin
                state_d = StDrain;
                drain_d = 1'b0;
                x_d     = '0;
                y_d     = '0;
                exp_d   = '0;
              end else begin
                exp_d = exp_q + ADDR_WIDTH'(1);
                if (x_q == XW'(LINE_LENGTH - 1)) begin
                  x_d = '0;
                  y_d = y_q + YW'(1);
                end else begin
                  x_d = x_q + XW'(1);
                end
              end
            end else if (i_addr == '0) begin
              // Resync: this pixel restarts the frame
              set_sync  = 1'b1;
              clr_cnt   = 1'b1;
              take      = 1'b1;
              at_origin = 1'b1;
              x_d       = XW'(1);
              y_d       = '0;
              exp_d     = ADDR_WIDTH'(1);
            end else begin
              set_sync = 1'b1;
              clr_cnt  = 1'b1;
              state_d  = StWaitSof;
              x_d      = '0;
              y_d      = '0;
              exp_d    = '0;
            end
          end
        end
        StDrain: begin
          set_drop = i_valid;
          drain_d  = 1'b1;
          if (drain_q) begin
            state_d = StResolve;
            idx_d   = '0;
          end
        end
        StResolve: begin
          set_drop = i_valid;
          idx_d    = idx_q + 4'd1;
          if (idx_q == 4'd8) begin
            state_d = StCommit;
            idx_d   = '0;
          end
        end
        StCommit: begin
          set_drop = i_valid;
          commit   = 1'b1;
          clr_cnt  = 1'b1;
          state_d  = StWaitSof;
        end
        default: state_d = StWaitSof;
      endcase
    end
  end

  // Winner of the cell under resolution; strict compare keeps ties on the lower code
  logic [CNT_WIDTH-1:0] best_cnt;
  logic [2:0]           best_cls;
  logic [2:0]           res;
  always_comb begin
    best_cnt = cnt_q[idx_q][0];
    best_cls = 3'd1;
    for (int k = 1; k < 5; k++) begin
      if (cnt_q[idx_q][k] > best_cnt) begin
        best_cnt = cnt_q[idx_q][k];
        best_cls = 3'(k + 1);
      end
    end
    res = (best_cnt < CNT_WIDTH'(MIN_COUNT)) ? 3'd0 : best_cls;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q      <= StWaitSof;
      x_q          <= '0;
      y_q          <= '0;
      exp_q        <= '0;
      drain_q      <= 1'b0;
      idx_q        <= '0;
      s1_valid_q   <= 1'b0;
      s1_class_q   <= '0;
      s1_cell_q    <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      drop_err_q   <= 1'b0;
      for (int c = 0; c < 9; c++) begin
        shadow_q[c] <= '0;
        color_q[c]  <= '0;
        for (int k = 0; k < 5; k++) cnt_q[c][k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      exp_q        <= exp_d;
      drain_q      <= drain_d;
      idx_q        <= idx_d;
      s1_valid_q   <= take && (class_in != 3'd0);
      s1_class_q   <= class_in;
      s1_cell_q    <= cell_in;
      frame_done_q <= commit;
      sync_err_q   <= sync_err_q | set_sync;
      drop_err_q   <= drop_err_q | set_drop;
      for (int c = 0; c < 9; c++) begin
        for (int k = 0; k < 5; k++) begin
          if (clr_cnt) begin
            cnt_q[c][k] <= '0;
          end else if (s1_valid_q && s1_cell_q == 4'(c) && s1_class_q == 3'(k + 1) &&
                       cnt_q[c][k] != '1) begin
            cnt_q[c][k] <= cnt_q[c][k] + CNT_WIDTH'(1);
          end
        end
      end
      if (state_q == StResolve && !i_flush) shadow_q[idx_q] <= res;
      if (commit) begin
        for (int c = 0; c < 9; c++) color_q[c] <= shadow_q[c];
      end
    end
  end

  assign o_color0     = color_q[0];
  assign o_color1     = color_q[1];
  assign o_color2     = color_q[2];
  assign o_color3     = color_q[3];
  assign o_color4     = color_q[4];
  assign o_color5     = color_q[5];
  assign o_color6     = color_q[6];
  assign o_color7     = color_q[7];
  assign o_color8     = color_q[8];
  assign o_frame_done = frame_done_q;
  assign o_sync_err   = sync_err_q;
  assign o_drop_err   = drop_err_q;

endmodule

// File: doc/region_color_vote.md
Name: region_color_vote

Overview:
Per-frame colour vote stage in the colour-detection path. Consumes the filtered RGB565 pixel stream with its frame-buffer write address and strobe, exactly as they are written to the frame buffer. Classifies each pixel into one of six colour classes and accumulates per-class counts for each cell of a 3x3 grid. At end of frame it resolves the winning class per cell and presents nine 3-bit colour codes to the display overlay.

Parameters:
LINE_LENGTH, 480, pixels per line; must be divisible by 3.
LINE_COUNT, 480, lines per frame; must be divisible by 3.
ADDR_WIDTH, 18, width of i_addr.
CNT_WIDTH, 15, per-class counter width; counters saturate at all-ones.
SAT_MIN, 32, 6-bit channel level treated as "strong".
DARK_MAX, 24, 6-bit channel level treated as "weak" (strictly below).
WHITE_MIN, 48, 6-bit level all channels must reach for white.
MIN_COUNT, 256, minimum winning count; below this the cell resolves to 0.

Ports:
i_clk  in  1  system clock (125 MHz)
i_rstn  in  1  asynchronous active-low reset
i_flush  in  1  pipeline flush: abandon current frame
i_data  in  16  RGB565 pixel: R[15:11], G[10:5], B[4:0]
i_addr  in  ADDR_WIDTH  linear pixel address, row-major, 0 = top-left
i_valid  in  1  pixel strobe; one pixel per cycle maximum
o_color0..o_color8  out  3 each  resolved class per cell, row-major (0 = top-left, 8 = bottom-right)
o_frame_done  out  1  one-cycle pulse when o_color* update
o_sync_err  out  1  sticky: address discontinuity seen
o_drop_err  out  1  sticky: pixel arrived while resolving

Behaviour:
- Reset: all o_color* = 0, o_frame_done = 0, o_sync_err = 0, o_drop_err = 0. All counters = 0, x = y = 0, state = WAIT_SOF.
- Channel expansion: r6 = {R, R[4]}, g6 = G, b6 = {B, B[4]}.
- Classification, first match wins:
  - 1 white: r6, g6 and b6 all >= WHITE_MIN.
  - 2 yellow: r6 >= SAT_MIN, g6 >= SAT_MIN, b6 < DARK_MAX.
  - 3 red: r6 >= SAT_MIN, g6 < DARK_MAX, b6 < DARK_MAX.
  - 4 green: g6 >= SAT_MIN, r6 < DARK_MAX, b6 < DARK_MAX.
  - 5 blue: b6 >= SAT_MIN, r6 < DARK_MAX, g6 < DARK_MAX.
  - 0 otherwise. Class 0 is never counted.
- Cell index: cx = 0/1/2 for x in [0, L/3), [L/3, 2L/3), [2L/3, L); cy likewise from y. Cell = 3*cy + cx. x and y come from internal counters; no division of i_addr.
- Pipeline:
  - Stage 1 registers class, cell and address check.
  - Stage 2 increments counter[cell][class].
  - A pixel strobed on cycle N is counted on edge N+2.
- States:
  - WAIT_SOF: ignore pixels until i_valid with i_addr == 0; that pixel is processed, x = 1, y = 0, go to ACCUM.
  - ACCUM: each valid pixel must have i_addr == expected address (y*L + x, kept as a running counter).
    - Mismatch with i_addr == 0: resync; counters cleared; pixel counted as frame start; o_sync_err set.
    - Mismatch with i_addr != 0: counters cleared; o_sync_err set; go to WAIT_SOF.
    - The pixel at address L*LC-1: wait for stage 2 to drain (2 cycles), then go to RESOLVE.
  - RESOLVE: 9 cycles, one cell per cycle in order 0..8.
    - Winner = class 1..5 with the largest count; ties go to the lowest class code.
    - If the winner's count < MIN_COUNT, the result is 0.
    - Results are written to shadow registers.
  - COMMIT: 1 cycle. All nine o_color* load from shadow simultaneously; o_frame_done = 1; all counters cleared; go to WAIT_SOF.
- Valid pixel during RESOLVE/COMMIT: dropped, o_drop_err set, state unaffected.
- i_flush, any state: counters cleared, in-flight pipeline discarded, go to WAIT_SOF. o_color* and sticky flags hold. No o_frame_done.
- Flush and valid in the same cycle: flush wins and the pixel is dropped silently.
- Sticky flags clear only on reset.
- Latency: o_frame_done asserts 13 cycles after the last pixel's strobe (2 pipeline + 1 drain + 9 resolve + 1 commit).

Test Plan:
- Params L = LC = 6, MIN_COUNT = 1. Full frame of 16'hF800 -> o_frame_done 13 cycles after the last pixel; all o_color* = 3.
- Per-cell fill: cell0 16'h07E0, cell4 16'h001F, cell8 16'hFFFF, cell2 16'hFFE0, others 16'h0000 -> colors {0 = 4, 2 = 2, 4 = 5, 8 = 1}, rest 0.
- Tie: cell0 has 2 px 16'hF800 and 2 px 16'h07E0; MIN_COUNT = 1 -> o_color0 = 3 (lower code wins). MIN_COUNT = 3, same stimulus -> o_color0 = 0.
- Skip address 10 mid-frame -> o_sync_err = 1, no o_frame_done. A following clean frame of red -> all 3, o_frame_done pulses once.
- i_flush at pixel 20 of a red frame, then a full blue frame -> single o_frame_done; all o_color* = 5; prior outputs held during flush.
- Valid pixel 5 cycles after the last pixel -> o_drop_err = 1; frame result unchanged. Reset mid-RESOLVE -> all outputs 0, next frame resolves normally.
